// File: rtl/proc_mem_responder.sv
// proc_mem_responder: instruction/data memory responder for the ARM-subset core.
// The host preloads program and pixel memory while the core is held, releases it
// with a start pulse, and after the halt word (0x00000000) is fetched the core is
// held again so the host can dump the processed pixels.
module proc_mem_responder #(
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 256,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       pc,
   output logic [31:0]      instruction,
   input  logic [31:0]      address,
   input  logic [31:0]      writeData,
   input  logic             WR,
   output logic [31:0]      readData,
   output logic             cpu_hold,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             load_sel,
   input  logic [15:0]      load_addr,
   input  logic [31:0]      load_data,
   input  logic             start,
   input  logic [15:0]      host_rd_addr,
   output logic [7:0]       host_rd_data,
   output logic             done,
   output logic             fault,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [31:0]     imem [IMEM_DEPTH];
   logic [7:0]      dmem [DMEM_DEPTH];

   logic [1:0]      state_r;
   logic [1:0]      next_state_s;
   logic [31:0]     pc_idx_s;
   logic            imem_hit_s;
   logic            daddr_ok_s;
   logic            halt_s;
   logic            store_s;
   logic            load_acc_s;
   logic            load_ok_s;
   logic            imem_we_s;
   logic            fault_set_s;
   logic            host_ok_s;
   logic            dmem_we_s;
   logic [DA_W-1:0] dmem_wa_s;
   logic [7:0]      dmem_wd_s;
   logic            unused_s;

   // Byte-offset bits of pc and the upper store data are architecturally ignored.
   assign unused_s   = ^{pc[1:0], writeData[31:8]};

   assign pc_idx_s   = {26'd0, pc[7:2]};
   assign imem_hit_s = (pc_idx_s < 32'(IMEM_DEPTH));
   assign daddr_ok_s = (address < 32'(DMEM_DEPTH));
   assign host_ok_s  = ({16'd0, host_rd_addr} < 32'(DMEM_DEPTH));
   assign load_acc_s = (state_r == ST_IDLE) && load_valid;
   assign load_ok_s  = load_sel ? ({16'd0, load_addr} < 32'(DMEM_DEPTH))
                                : ({16'd0, load_addr} < 32'(IMEM_DEPTH));
   assign imem_we_s  = load_acc_s && !load_sel && load_ok_s;

   // Instruction fetch: only a running core sees program words; otherwise zero.
   always_comb begin
      instruction = 32'h0000_0000;
      if ((state_r == ST_RUN) && imem_hit_s) begin
         instruction = imem[pc_idx_s[IA_W-1:0]];
      end else begin
         instruction = 32'h0000_0000;
      end
   end

   // Data read: zero-extended pixel byte, zero when the address is outside dmem.
   always_comb begin
      readData = 32'h0000_0000;
      if (daddr_ok_s) begin
         readData = {24'd0, dmem[address[DA_W-1:0]]};
      end else begin
         readData = 32'h0000_0000;
      end
   end

   // Halt, store qualification and sticky-fault sources for this cycle.
   always_comb begin
      halt_s      = (state_r == ST_RUN) && (instruction == 32'h0000_0000);
      store_s     = (state_r == ST_RUN) && !halt_s && WR && daddr_ok_s;
      fault_set_s = (load_acc_s && !load_ok_s) || ((state_r == ST_RUN) && !daddr_ok_s);
   end

   // Next-state: a load beat wins over start in IDLE; start in RUN is ignored.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_valid) begin
               next_state_s = ST_IDLE;
            end else if (start) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (halt_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DONE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Single dmem write port shared by host pixel loads (IDLE) and core stores (RUN).
   always_comb begin
      dmem_we_s = 1'b0;
      dmem_wa_s = {DA_W{1'b0}};
      dmem_wd_s = 8'h00;
      if (load_acc_s && load_sel && load_ok_s) begin
         dmem_we_s = 1'b1;
         dmem_wa_s = load_addr[DA_W-1:0];
         dmem_wd_s = load_data[7:0];
      end else if (store_s) begin
         dmem_we_s = 1'b1;
         dmem_wa_s = address[DA_W-1:0];
         dmem_wd_s = writeData[7:0];
      end else begin
         dmem_we_s = 1'b0;
      end
   end

   // Memory arrays keep their contents across reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (imem_we_s) begin
            imem[load_addr[IA_W-1:0]] <= load_data;
         end
         if (dmem_we_s) begin
            dmem[dmem_wa_s] <= dmem_wd_s;
         end
      end
   end

   // Control state, registered status outputs and the saturating run-cycle counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cpu_hold    <= 1'b1;
         load_ready  <= 1'b1;
         done        <= 1'b0;
         fault       <= 1'b0;
         cycle_count <= {CNT_W{1'b0}};
      end else begin
         state_r    <= next_state_s;
         cpu_hold   <= (next_state_s != ST_RUN);
         load_ready <= (next_state_s == ST_IDLE);
         done       <= (next_state_s == ST_DONE);
         if (fault_set_s) begin
            fault <= 1'b1;
         end
         if ((state_r == ST_IDLE) && (next_state_s == ST_RUN)) begin
            cycle_count <= {CNT_W{1'b0}};
         end else if ((state_r == ST_RUN) && (cycle_count != {CNT_W{1'b1}})) begin
            cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Host dump port: registered read of the pre-write byte, zero when out of range.
   always_ff @(posedge clk) begin
      if (!rst) begin
         host_rd_data <= 8'h00;
      end else if (host_ok_s) begin
         host_rd_data <= dmem[host_rd_addr[DA_W-1:0]];
      end else begin
         host_rd_data <= 8'h00;
      end
   end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Self-checking bench for proc_mem_responder: a behavioural model of the memory
// image and run mode is compared against the DUT every negedge, plus directed
// literal checks of the example program, store/dump, fault, reset and saturation.
module tb_proc_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pc;
   logic [31:0] instruction;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        WR;
   logic [31:0] readData;
   logic        cpu_hold;
   logic        load_valid;
   logic        load_ready;
   logic        load_sel;
   logic [15:0] load_addr;
   logic [31:0] load_data;
   logic        start;
   logic [15:0] host_rd_addr;
   logic [7:0]  host_rd_data;
   logic        done;
   logic        fault;
   logic [15:0] cycle_count;

   always #5 clk = ~clk;

   proc_mem_responder dut (
      .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
      .address(address), .writeData(writeData), .WR(WR), .readData(readData),
      .cpu_hold(cpu_hold), .load_valid(load_valid), .load_ready(load_ready),
      .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
      .start(start), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
      .done(done), .fault(fault), .cycle_count(cycle_count)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   bit mem_known = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 = idle (host owns memory), 1 = core running, 2 = halted
   logic [31:0] m_imem [64];
   logic [7:0]  m_dmem [256];
   int          m_mode;
   logic        m_fault;
   int          m_cnt;
   logic [7:0]  m_hrd;

   // Model update at each clock edge from the same inputs the DUT samples.
   always @(posedge clk) begin
      if (!rst) begin
         m_mode  <= 0;
         m_fault <= 1'b0;
         m_cnt   <= 0;
         m_hrd   <= 8'h00;
      end else begin
         m_hrd <= (host_rd_addr < 16'd256) ? m_dmem[host_rd_addr[7:0]] : 8'h00;
         if (m_mode == 0) begin
            if (load_valid) begin
               if (!load_sel) begin
                  if (load_addr < 16'd64) m_imem[load_addr[5:0]] <= load_data;
                  else m_fault <= 1'b1;
               end else begin
                  if (load_addr < 16'd256) m_dmem[load_addr[7:0]] <= load_data[7:0];
                  else m_fault <= 1'b1;
               end
            end else if (start) begin
               m_mode <= 1;
               m_cnt  <= 0;
            end
         end else if (m_mode == 1) begin
            m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (address >= 32'd256) m_fault <= 1'b1;
            if (m_imem[int'(pc) / 4] == 32'h0) m_mode <= 2;
            else if (WR && address < 32'd256) m_dmem[address[7:0]] <= writeData[7:0];
         end else if (start) begin
            m_mode <= 0;
         end
      end
   end

   // Compare process: all outputs against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_hold", 32'(cpu_hold), 32'(m_mode != 1));
         chk("load_ready", 32'(load_ready), 32'(m_mode == 0));
         chk("done", 32'(done), 32'(m_mode == 2));
         chk("fault", 32'(fault), 32'(m_fault));
         chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
         chk("instruction", instruction, (m_mode == 1) ? m_imem[int'(pc) / 4] : 32'h0);
         if (mem_known) begin
            chk("readData", readData,
                (address < 32'd256) ? {24'h0, m_dmem[address[7:0]]} : 32'h0);
            chk("host_rd_data", 32'(host_rd_data), 32'(m_hrd));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic sel, input logic [15:0] a, input logic [31:0] d);
      load_valid = 1'b1;
      load_sel   = sel;
      load_addr  = a;
      load_data  = d;
      cyc();
      load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   logic [31:0] prog [4];
   int          h;

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      prog[0] = 32'he3a00002; prog[1] = 32'he2800002;
      prog[2] = 32'he3a01002; prog[3] = 32'h00000000;
      rst = 1'b0; pc = 8'd0; address = 32'd0; writeData = 32'd0; WR = 1'b0;
      load_valid = 1'b0; load_sel = 1'b0; load_addr = 16'd0; load_data = 32'd0;
      start = 1'b0; host_rd_addr = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_load_ready", 32'(load_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_cycle_count", 32'(cycle_count), 32'd0);
      chk("rst_host_rd_data", 32'(host_rd_data), 32'd0);
      rst = 1'b1;

      // Preload all of program and pixel memory.
      for (int i = 0; i < 64; i++) beat(1'b0, 16'(i), (i < 4) ? prog[i] : ($urandom | 32'h1));
      for (int i = 0; i < 256; i++) beat(1'b1, 16'(i), $urandom);
      mem_known = 1'b1;

      // Example program with one store on the first RUN cycle.
      pulse_start();
      chk("start_cpu_hold", 32'(cpu_hold), 32'd0);
      address = 32'h10; WR = 1'b1; writeData = 32'h123456A5; #1;
      chk("instr_pc0", instruction, 32'he3a00002);
      cyc();
      pc = 8'h04; WR = 1'b0; #1;
      chk("readData_0x10", readData, 32'h000000A5);
      chk("instr_pc4", instruction, 32'he2800002);
      cyc();
      pc = 8'h08; #1;
      chk("instr_pc8", instruction, 32'he3a01002);
      cyc();
      pc = 8'h0C; #1;
      chk("instr_pcC", instruction, 32'h00000000);
      cyc();
      chk("prog_done", 32'(done), 32'd1);
      chk("prog_cycle_count", 32'(cycle_count), 32'd4);
      chk("prog_fault", 32'(fault), 32'd0);
      pc = 8'h00; host_rd_addr = 16'h10;
      cyc();
      chk("dump_0x10", 32'(host_rd_data), 32'hA5);

      // Out-of-range store: fault sticks through DONE->IDLE.
      pulse_start();
      chk("done_cleared", 32'(done), 32'd0);
      pulse_start();
      address = 32'h100; WR = 1'b1; writeData = $urandom;
      cyc();
      chk("oob_store_fault", 32'(fault), 32'd1);
      WR = 1'b0; address = 32'h0;
      pc = 8'h04; cyc();
      pc = 8'h08; cyc();
      pc = 8'h0C; cyc();
      pc = 8'h00;
      pulse_start();
      chk("fault_sticky", 32'(fault), 32'd1);
      chk("count_retained", 32'(cycle_count), 32'd4);

      // Load beat and start together: load wins, stay in IDLE.
      load_valid = 1'b1; load_sel = 1'b1; load_addr = 16'h20; load_data = 32'h5A;
      start = 1'b1;
      cyc();
      load_valid = 1'b0; start = 1'b0;
      chk("ld_start_hold", 32'(cpu_hold), 32'd1);
      chk("ld_start_ready", 32'(load_ready), 32'd1);
      host_rd_addr = 16'h20;
      cyc();
      chk("ld_start_dump", 32'(host_rd_data), 32'h5A);
      pulse_start();
      chk("start_alone_run", 32'(cpu_hold), 32'd0);

      // Reset during RUN after three stores.
      address = 32'h30; writeData = 32'h11; WR = 1'b1; cyc();
      pc = 8'h04; address = 32'h31; writeData = 32'h22; cyc();
      pc = 8'h08; address = 32'h32; writeData = 32'h33; cyc();
      rst = 1'b0; address = 32'h33; writeData = 32'h44; cyc();
      rst = 1'b1; WR = 1'b0; pc = 8'h00; address = 32'h0;
      chk("midrst_hold", 32'(cpu_hold), 32'd1);
      chk("midrst_count", 32'(cycle_count), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_fault", 32'(fault), 32'd0);
      host_rd_addr = 16'h30; cyc();
      chk("midrst_dump30", 32'(host_rd_data), 32'h11);
      host_rd_addr = 16'h32; cyc();
      chk("midrst_dump32", 32'(host_rd_data), 32'h33);
      host_rd_addr = 16'h33; cyc();

      // Out-of-range dump gives zero without fault; out-of-range load faults.
      host_rd_addr = 16'd300; cyc();
      chk("oob_dump_zero", 32'(host_rd_data), 32'd0);
      chk("oob_dump_nofault", 32'(fault), 32'd0);
      beat(1'b1, 16'd300, 32'hFF);
      chk("oob_load_fault", 32'(fault), 32'd1);
      host_rd_addr = 16'd44; cyc();

      // Randomized runs with a random halt position.
      for (int r = 0; r < 15; r++) begin
         h = $urandom_range(0, 63);
         for (int i = 0; i < 64; i++) begin
            host_rd_addr = 16'($urandom_range(0, 300));
            beat(1'b0, 16'(i), (i == h) ? 32'h0 : ($urandom | 32'h1));
         end
         for (int i = 0; i < 4; i++) beat(1'b1, 16'($urandom_range(0, 255)), $urandom);
         pulse_start();
         for (int k = 0; k < 100; k++) begin
            pc = 8'($urandom);
            address = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            WR = 1'($urandom);
            writeData = $urandom;
            host_rd_addr = ($urandom_range(0, 1) == 0) ? 16'(address) : 16'($urandom_range(0, 300));
            start = ($urandom_range(0, 9) == 0);
            load_valid = ($urandom_range(0, 9) == 0);
            load_sel = 1'($urandom);
            load_addr = 16'($urandom_range(0, 255));
            load_data = $urandom;
            cyc();
            if (m_mode != 1) break;
         end
         load_valid = 1'b0; start = 1'b0; WR = 1'b0;
         address = 32'($urandom_range(0, 255));
         if (m_mode == 1) begin
            pc = 8'(h * 4);
            cyc();
         end
         chk("rand_halt_done", 32'(done), 32'd1);
         pulse_start();
      end

      // Long run without halt: counter saturates.
      pc = 8'(((h + 1) % 64) * 4); address = 32'h0; WR = 1'b0;
      pulse_start();
      repeat (70000) cyc();
      chk("sat_count", 32'(cycle_count), 32'hFFFF);
      pc = 8'(h * 4);
      cyc();
      chk("sat_done", 32'(done), 32'd1);
      chk("sat_count_done", 32'(cycle_count), 32'hFFFF);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
Memory-side responder for the single-cycle ARM-subset processor: it answers instruction fetches (pc -> instruction) and data accesses (address/WR/writeData -> readData). A host port preloads program and pixel memory, then releases the processor. The block detects program end (fetched word 0x00000000), holds the core, and lets the host dump decrypted pixels. It sits between the processor top and the image I/O host logic.

Parameters:
IMEM_DEPTH, 64, instruction words; index = pc[7:2]; max 64
DMEM_DEPTH, 256, data bytes (pixels); byte index = address
CNT_W, 16, width of run-cycle counter

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous reset, active-low
pc  in  8  processor byte PC
instruction  out  32  fetched instruction word
address  in  32  processor data byte address
writeData  in  32  processor store data; only [7:0] stored
WR  in  1  processor store enable
readData  out  32  {24'b0, pixel byte}
cpu_hold  out  1  1 = processor must be held in reset/stall
load_valid  in  1  host load beat valid
load_ready  out  1  responder can accept load beat
load_sel  in  1  0 = imem, 1 = dmem
load_addr  in  16  word index (imem) or byte index (dmem)
load_data  in  32  load payload; dmem uses [7:0]
start  in  1  one-cycle pulse: IDLE->RUN or DONE->IDLE
host_rd_addr  in  16  dmem byte index for dump
host_rd_data  out  8  registered dmem read
done  out  1  program reached halt word
fault  out  1  sticky out-of-range access
cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (rst==0 at posedge): state IDLE; done=0, fault=0, cycle_count=0, host_rd_data=0. Memory arrays not cleared. Reset mid-RUN aborts run; already-committed stores persist.
- States: IDLE, RUN, DONE. Outputs: IDLE cpu_hold=1, load_ready=1; RUN cpu_hold=0, load_ready=0; DONE cpu_hold=1, load_ready=0, done=1.
- IDLE: load beat accepted when load_valid&&load_ready; written at that posedge. load_addr >= depth of selected memory: beat consumed, no write, fault<=1. start with no load_valid -> RUN next cycle, cycle_count<=0. start and load_valid together: load accepted, start ignored, stay IDLE.
- instruction (combinational): RUN and pc[7:2] < IMEM_DEPTH -> imem[pc[7:2]]; else 32'h0. pc[1:0] ignored.
- readData (combinational): address < DMEM_DEPTH -> {24'b0, dmem[address]}; else 0, and fault<=1 at posedge if in RUN.
- Store: RUN && WR && address < DMEM_DEPTH -> dmem[address] <= writeData[7:0] at posedge. Out-of-range store: no write, fault<=1. WR ignored outside RUN.
- Halt: in RUN, instruction==32'h0 at a posedge -> DONE next cycle; that cycle's WR is ignored. cycle_count increments every RUN posedge including the halt cycle, saturates at all-ones; frozen in IDLE/DONE.
- DONE: start -> IDLE (done clears, fault/cycle_count retained until next RUN entry clears cycle_count; fault only cleared by reset).
- Host dump: host_rd_data <= dmem[host_rd_addr] every posedge in any state, 1-cycle latency; out-of-range -> 0, no fault. Simultaneous store and dump of same byte returns old value.

Test Plan:
- Reset then load imem[0..3]={e3a00002,e2800002,e3a01002,0}, start -> cpu_hold falls 1 cycle after start; instruction tracks pc 0,4,8; at pc=0x0C done=1 next cycle, cycle_count=4.
- RUN with address=0x10, WR=1, writeData=0x1234_56A5 -> dmem[0x10]=0xA5; next-cycle readData at 0x10 = 0x0000_00A5; host_rd_addr=0x10 in DONE gives 0xA5 one cycle later.
- Store to address=0x100 (DMEM_DEPTH 256) -> no write, fault=1 and stays 1 through DONE->IDLE; clears only on rst=0.
- load_valid and start same cycle in IDLE -> beat written, state remains IDLE, cpu_hold=1; next start alone enters RUN.
- rst=0 during RUN at cycle 3 -> next cycle IDLE, cpu_hold=1, cycle_count=0, done=0; dmem bytes written before reset still readable via host port.
- Run program with no halt word for 70000 cycles (CNT_W=16) -> cycle_count saturates at 0xFFFF.
